// File: rtl/adder_pkg.sv
// adder_pkg: shared segmentation helpers and latency constants for adder_pipelined
package adder_pkg;
  localparam int DEF_WIDTH = 22;
  localparam int DEF_STAGES = 1;
  localparam int LATENCY = DEF_STAGES + 1;
  function automatic int seg_lo(input int idx, input int w, input int s);
    return idx * (w / s);
  endfunction
  function automatic int seg_width(input int idx, input int w, input int s);
    return idx == s - 1 ? w - (s - 1) * (w / s) : w / s;
  endfunction
  function automatic int latency(input int s);
    return s + 1;
  endfunction
endpackage

// File: rtl/adder_segment.sv
// adder_segment: registered WIDTH-bit carry segment; in clk, reset_n, a, b, cin; out s, cout
module adder_segment #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {cout, s} <= '0;
    else {cout, s} <= {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/adder_pipelined.sv
// adder_pipelined: STAGES-segment pipelined add/sub; in clk, reset_n, in_valid, sub, a, b; out out_valid, sum
module adder_pipelined
  import adder_pkg::*;
#(
  parameter int ADDER_WIDTH = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic                   sub,
  input  logic [ADDER_WIDTH-1:0] a,
  input  logic [ADDER_WIDTH-1:0] b,
  output logic                   out_valid,
  output logic [ADDER_WIDTH:0]   sum
);
  localparam int W = ADDER_WIDTH;
  localparam int LAT = latency(STAGES);
  if (STAGES < 1 || STAGES > W) begin : g_bad
    $error("adder_pipelined: STAGES must be within 1..ADDER_WIDTH");
  end
  logic [STAGES-1:0] sub_sk;
  logic [STAGES-1:0] cy;
  logic [W-1:0] res;
  logic [LAT-1:0] vp;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sub_sk <= '0;
      vp <= '0;
    end else begin
      sub_sk[0] <= sub;
      for (int i = 1; i < STAGES; i++) sub_sk[i] <= sub_sk[i-1];
      vp <= {vp[LAT-2:0], in_valid};
    end
  assign out_valid = vp[LAT-1];
  assign sum = {cy[STAGES-1], res};
  for (genvar j = 0; j < STAGES; j++) begin : g_seg
    localparam int LO = seg_lo(j, W, STAGES);
    localparam int SW = seg_width(j, W, STAGES);
    localparam int D = STAGES - 1 - j;
    logic [SW-1:0] a_sk [j+1];
    logic [SW-1:0] b_sk [j+1];
    logic [SW-1:0] bp;
    logic [SW-1:0] s;
    logic cin;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        for (int i = 0; i <= j; i++) begin
          a_sk[i] <= '0;
          b_sk[i] <= '0;
        end
      end else begin
        a_sk[0] <= a[LO +: SW];
        b_sk[0] <= b[LO +: SW];
        for (int i = 1; i <= j; i++) begin
          a_sk[i] <= a_sk[i-1];
          b_sk[i] <= b_sk[i-1];
        end
      end
    assign bp = sub_sk[j] ? ~b_sk[j] : b_sk[j];
    if (j == 0) begin : g_c0
      assign cin = sub_sk[0];
    end else begin : g_cn
      assign cin = cy[j-1];
    end
    adder_segment #(.WIDTH(SW)) u_seg (
      .clk    (clk),
      .reset_n(reset_n),
      .a      (a_sk[j]),
      .b      (bp),
      .cin    (cin),
      .s      (s),
      .cout   (cy[j])
    );
    if (D == 0) begin : g_nd
      assign res[LO +: SW] = s;
    end else begin : g_d
      logic [SW-1:0] dsk [D];
      always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
          for (int i = 0; i < D; i++) dsk[i] <= '0;
        end else begin
          dsk[0] <= s;
          for (int i = 1; i < D; i++) dsk[i] <= dsk[i-1];
        end
      assign res[LO +: SW] = dsk[D-1];
    end
  end
endmodule

// File: tb/tb_adder_pipelined.sv
// tb_adder_pipelined: table-driven and sequence checks of adder_pipelined across four configurations
module tb_adder_pipelined;
  logic clk = 0, reset_n = 0, in_valid = 0, sub = 0, v5 = 0, sub5 = 0;
  logic [21:0] a = '0, b = '0;
  logic [4:0] a5 = '0, b5 = '0;
  logic o1, o4, o3, o5;
  logic [22:0] s1, s4, s3;
  logic [5:0] s5;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {logic [22:0] exp; int due;} exp_t;
  typedef struct {logic sub; logic [21:0] a; logic [21:0] b; logic [22:0] exp;} vec_t;
  exp_t q[4][$];
  vec_t vecs[11];
  int lat[4] = '{2, 5, 4, 6};
  string nm[4] = '{"s1", "s4", "s3", "w5s5"};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  adder_pipelined #(.ADDER_WIDTH(22), .STAGES(1)) u1 (.clk(clk), .reset_n(reset_n), .in_valid(in_valid), .sub(sub), .a(a), .b(b), .out_valid(o1), .sum(s1));
  adder_pipelined #(.ADDER_WIDTH(22), .STAGES(4)) u4 (.clk(clk), .reset_n(reset_n), .in_valid(in_valid), .sub(sub), .a(a), .b(b), .out_valid(o4), .sum(s4));
  adder_pipelined #(.ADDER_WIDTH(22), .STAGES(3)) u3 (.clk(clk), .reset_n(reset_n), .in_valid(in_valid), .sub(sub), .a(a), .b(b), .out_valid(o3), .sum(s3));
  adder_pipelined #(.ADDER_WIDTH(5), .STAGES(5)) u5 (.clk(clk), .reset_n(reset_n), .in_valid(v5), .sub(sub5), .a(a5), .b(b5), .out_valid(o5), .sum(s5));
  function automatic logic get_ov(input int i);
    return i == 0 ? o1 : i == 1 ? o4 : i == 2 ? o3 : o5;
  endfunction
  function automatic logic [22:0] get_sum(input int i);
    return i == 0 ? s1 : i == 1 ? s4 : i == 2 ? s3 : {17'b0, s5};
  endfunction
  function automatic logic [22:0] ref22(input logic s, input logic [21:0] x, input logic [21:0] y);
    return s ? {x >= y, 22'(x - y)} : {1'b0, x} + {1'b0, y};
  endfunction
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (!reset_n) begin
        if (get_ov(i) !== 1'b0 || get_sum(i) !== 23'd0) begin
          errors++;
          $display("FAIL %s reset_state: out_valid=%b sum=%h, required out_valid=0 sum=0", nm[i], get_ov(i), get_sum(i));
        end
      end else if (q[i].size() > 0 && q[i][0].due == cyc) begin
        if (get_ov(i) !== 1'b1 || get_sum(i) !== q[i][0].exp) begin
          errors++;
          $display("FAIL %s result@%0d: out_valid=%b sum=%h, required out_valid=1 sum=%h", nm[i], cyc, get_ov(i), get_sum(i), q[i][0].exp);
        end
        void'(q[i].pop_front());
      end else if (get_ov(i) !== 1'b0) begin
        errors++;
        $display("FAIL %s idle@%0d: out_valid=%b, required 0", nm[i], cyc, get_ov(i));
      end
    end
  end
  task automatic op22(input logic s, input logic [21:0] x, input logic [21:0] y, input logic [22:0] e);
    exp_t t;
    in_valid = 1; sub = s; a = x; b = y;
    for (int i = 0; i < 3; i++) begin
      t.exp = e;
      t.due = cyc + lat[i];
      q[i].push_back(t);
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic op5(input logic s, input logic [4:0] x, input logic [4:0] y, input logic [5:0] e);
    exp_t t;
    v5 = 1; sub5 = s; a5 = x; b5 = y;
    t.exp = {17'b0, e};
    t.due = cyc + lat[3];
    q[3].push_back(t);
    @(posedge clk); #1;
    v5 = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    vecs[0]  = '{1'b0, 22'h3FFFFF, 22'h000001, 23'h400000};
    vecs[1]  = '{1'b1, 22'h000005, 22'h000007, 23'h3FFFFE};
    vecs[2]  = '{1'b1, 22'h000007, 22'h000005, 23'h400002};
    vecs[3]  = '{1'b1, 22'h000000, 22'h000000, 23'h400000};
    vecs[4]  = '{1'b0, 22'h000000, 22'h000000, 23'h000000};
    vecs[5]  = '{1'b0, 22'h3FFFFF, 22'h3FFFFF, 23'h7FFFFE};
    vecs[6]  = '{1'b1, 22'h3FFFFF, 22'h3FFFFF, 23'h400000};
    vecs[7]  = '{1'b0, 22'h155555, 22'h2AAAAA, 23'h3FFFFF};
    vecs[8]  = '{1'b1, 22'h000000, 22'h000001, 23'h3FFFFF};
    vecs[9]  = '{1'b0, 22'h012345, 22'h00F0F0, 23'h021435};
    vecs[10] = '{1'b1, 22'h200000, 22'h100000, 23'h500000};
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    idle(2);
    op22(vecs[0].sub, vecs[0].a, vecs[0].b, vecs[0].exp);
    idle(8);
    for (int k = 1; k < 11; k++) begin
      op22(vecs[k].sub, vecs[k].a, vecs[k].b, vecs[k].exp);
      idle(1);
    end
    idle(8);
    for (int i = 0; i < 20; i++) begin
      logic [21:0] x, y;
      logic s;
      x = 22'(i * 22'h1F3A7);
      y = 22'h3FFFFF - 22'(i);
      s = i[0];
      op22(s, x, y, ref22(s, x, y));
    end
    idle(8);
    op5(1'b0, 5'h1F, 5'h1F, 6'h3E);
    op5(1'b1, 5'h00, 5'h00, 6'h20);
    op5(1'b1, 5'h03, 5'h05, 6'h1E);
    idle(10);
    op22(1'b0, 22'h000001, 22'h000002, 23'h000003);
    op22(1'b1, 22'h000009, 22'h000004, 23'h400005);
    op22(1'b0, 22'h3FFFFF, 22'h3FFFFF, 23'h7FFFFE);
    #1 reset_n = 0;
    for (int i = 0; i < 3; i++) q[i].delete();
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (get_ov(i) !== 1'b0 || get_sum(i) !== 23'd0) begin
        errors++;
        $display("FAIL %s async_reset: out_valid=%b sum=%h, required out_valid=0 sum=0", nm[i], get_ov(i), get_sum(i));
      end
    end
    @(posedge clk); #1;
    reset_n = 1;
    idle(12);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q[i].size() != 0) begin
        errors++;
        $display("FAIL %s drained: pending=%0d, required 0", nm[i], q[i].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_pipelined.md
Name: adder_pipelined

Overview:
- Parametrised successor to the registered two-operand adder benchmark.
- Operands and results are still registered. The carry chain is split into STAGES pipelined segments, so timing scales with width and depth in the arithmetic benchmark sweeps.
- Adds a subtract mode and a valid qualifier that travels alongside the data.
- Throughput is one operation per cycle, with no backpressure.

Parameters:
- ADDER_WIDTH, 22: operand width W; sum is W+1 bits.
- STAGES, 1: number of carry-chain segments, each ending in a register. Legal range is 1..ADDER_WIDTH; anything outside that range is an elaboration error.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a, b and sub are meaningful this cycle.
- sub  input  1  0 computes a+b; 1 computes a-b.
- a  input  ADDER_WIDTH  operand A, unsigned.
- b  input  ADDER_WIDTH  operand B, unsigned.
- out_valid  output  1  sum holds the result for a valid input.
- sum  output  ADDER_WIDTH+1  bits W-1:0 are the result mod 2^W; bit W is the carry-out.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Every register clears to 0: input regs, segment regs, skew regs, valid pipe and sum.
  - out_valid=0 and sum=0 while reset_n=0.
  - On release, normal operation starts at the next rising edge.
- Segmentation:
  - SEG = floor(W/STAGES).
  - Segments 0..STAGES-2 are SEG bits each; the top segment is W-(STAGES-1)*SEG bits, so it is always at least 1 bit.
  - Example: W=22, STAGES=4 gives 5,5,5,7.
- Pipeline:
  - Edge 0: a, b, sub and in_valid are captured into input registers, unconditionally every cycle.
  - Edge k (k=1..STAGES): segment k-1 adds its a slice, its b' slice and the registered carry from segment k-2. b' = sub ? ~b : b; carry-in of segment 0 is sub.
  - Higher, not-yet-used operand slices move forward through skew registers.
  - Lower, completed result slices are delayed through deskew registers so that all slices of one operation appear together.
  - The final segment's register is sum itself. Its carry-out lands in sum[W].
- Latency is STAGES+1 cycles from in_valid sampled to out_valid. STAGES=1 gives the legacy 2-cycle timing.
- out_valid is in_valid delayed by STAGES+1 registers.
- sum is valid only while out_valid=1. Data registers load every cycle regardless of valid, and sum content while out_valid=0 is unspecified.
- Subtract mode:
  - Result is (a - b) mod 2^W.
  - sum[W]=1 means no borrow (a>=b); sum[W]=0 means borrow.
- Back-to-back operations:
  - Operations on consecutive cycles are independent.
  - Operations may mix add and subtract freely.
  - Results come out in order, one per cycle.
  - No state carries between operations.
- Reset mid-operation: all in-flight operations are discarded, out_valid drops immediately (asynchronously), and no stale result appears after release.
- Boundary cases:
  - STAGES=W gives 1-bit segments.
  - a=b=0 with sub=1 gives sum={1,0}.

Decomposition:
- Shared package adder_pkg holds:
  - function seg_lo(index) returning the LSB of a segment;
  - function seg_width(index);
  - a localparam for the latency, STAGES+1.
- One sub-module, adder_segment, parametrised by width:
  - inputs: registered a slice, b slice and carry-in;
  - outputs: registered sum slice and carry-out.
- The top level instantiates STAGES of these with a generate loop and owns the skew/deskew registers and the valid pipe.

Test Plan:
- W=22, STAGES=1: a=0x3FFFFF, b=0x000001, sub=0, in_valid for 1 cycle -> 2 cycles later out_valid=1 and sum=0x400000; out_valid=0 on the following cycle.
- W=22, STAGES=4: a=0x3FFFFF, b=0x000001 -> 5 cycles later sum=0x400000. This checks that the carry ripples through all 4 segments.
- W=22, STAGES=4, sub=1:
  - a=5, b=7 -> sum=0x3FFFFE (bit22=0, borrow).
  - a=7, b=5 -> sum=0x400002.
- W=22, STAGES=3, streaming: for 20 consecutive cycles feed a=i*0x1F3A7, b=0x3FFFFF-i, with sub alternating -> 20 consecutive out_valid cycles starting 4 cycles later, each sum matching the reference model in order.
- W=22, STAGES=4, reset mid-flight: issue 3 valid operations, then pulse reset_n low for 1 cycle after the 2nd edge -> out_valid=0 and sum=0 during reset, and no out_valid is ever produced for those 3 operations.
- W=5, STAGES=5 (1-bit segments): a=0x1F, b=0x1F, sub=0 -> 6 cycles later sum=0x3E.
